// File: rtl/zorro2_autoconfig_host.sv
// rtl/zorro2_autoconfig_host.sv - Zorro II autoconfig host: walks the config chain at $E80000 and assigns FastRAM slots
module zorro2_autoconfig_host #(
    parameter int WAIT_CLKS  = 4,
    parameter int MAX_BOARDS = 5
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        start,
    output logic [22:0] ADDR,
    inout  wire  [3:0]  DBUS,
    output logic        ASn,
    output logic        UDSn,
    output logic        LDSn,
    output logic        RWn,
    output logic        CFGOUTn,
    output logic        busy,
    output logic        done,
    output logic [3:0]  boards_found,
    output logic [7:0]  slot_map,
    output logic        overflow
);
    localparam int CW = (WAIT_CLKS > 2) ? $clog2(WAIT_CLKS) : 1;
    localparam logic [CW-1:0] STROBE_LAST = CW'(WAIT_CLKS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_TYPE, S_RD_SIZE, S_RD_MFG0, S_RD_MFG1, S_RD_MFG2, S_RD_MFG3,
        S_DECIDE, S_WR_LO, S_WR_HI, S_WR_SHUT, S_NEXT, S_DONE
    } state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_REC1, PH_REC2} phase_t;

    state_t          r_state, w_state_nxt;
    phase_t          r_phase, w_phase_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_type;
    logic [2:0]      r_size;
    logic [15:0]     r_mfg;
    logic [2:0]      r_slot_idx;
    logic [7:0]      r_slot_mask;
    logic            r_probe;
    logic            r_cfgout_n, r_busy, r_done, r_overflow;
    logic [3:0]      r_found;
    logic [7:0]      r_slot_map;

    logic            w_is_bus, w_is_wr, w_bus_end, w_sample, w_mem, w_fit, w_drive;
    logic [7:0]      w_reg, w_need, w_cand, w_mask;
    logic [2:0]      w_idx;
    logic [3:0]      w_wdata;

    assign w_is_wr  = (r_state == S_WR_LO) || (r_state == S_WR_HI) || (r_state == S_WR_SHUT);
    assign w_is_bus = w_is_wr || (r_state inside {S_RD_TYPE, S_RD_SIZE, S_RD_MFG0,
                                                  S_RD_MFG1, S_RD_MFG2, S_RD_MFG3});
    assign w_mem    = (r_type[2:1] == 2'b11) && r_type[0];

    // Register index is the byte offset >> 1 (A8..A1).
    always_comb begin
        w_reg = 8'h00;
        case (r_state)
            S_RD_SIZE: w_reg = 8'h01;
            S_RD_MFG0: w_reg = 8'h08;
            S_RD_MFG1: w_reg = 8'h09;
            S_RD_MFG2: w_reg = 8'h0A;
            S_RD_MFG3: w_reg = 8'h0B;
            S_WR_HI:   w_reg = 8'h24;
            S_WR_LO:   w_reg = 8'h25;
            S_WR_SHUT: w_reg = 8'h26;
            default:   w_reg = 8'h00;
        endcase
    end

    // First-fit search; iterating downward lets the lowest aligned free index win.
    always_comb begin
        w_need = (r_size == 3'b000) ? 8'h0F : (r_size == 3'b111) ? 8'h03 : 8'h01;
        w_fit  = 1'b0;
        w_idx  = 3'd0;
        w_mask = 8'h00;
        w_cand = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            w_cand = w_need << i;
            if (((w_cand & r_slot_map) == 8'h00) &&
                ((w_need == 8'h0F) ? (i == 0) : (w_need == 8'h03) ? (i[0] == 1'b0) : 1'b1)) begin
                w_fit  = 1'b1;
                w_idx  = 3'(i);
                w_mask = w_cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_IDLE;
            r_phase <= PH_SETUP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        w_bus_end   = 1'b0;
        w_sample    = 1'b0;
        if (w_is_bus) begin
            case (r_phase)
                PH_SETUP: begin
                    w_phase_nxt = PH_STROBE;
                    w_cnt_nxt   = '0;
                end
                PH_STROBE: begin
                    if (r_cnt == STROBE_LAST) begin
                        w_phase_nxt = PH_REC1;
                        w_sample    = !w_is_wr;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                PH_REC1: w_phase_nxt = PH_REC2;
                default: begin
                    w_phase_nxt = PH_SETUP;
                    w_bus_end   = 1'b1;
                end
            endcase
        end
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_RD_TYPE;
            S_RD_TYPE: if (w_bus_end) w_state_nxt = S_RD_SIZE;
            S_RD_SIZE: if (w_bus_end) w_state_nxt = S_RD_MFG0;
            S_RD_MFG0: if (w_bus_end) w_state_nxt = S_RD_MFG1;
            S_RD_MFG1: if (w_bus_end) w_state_nxt = S_RD_MFG2;
            S_RD_MFG2: if (w_bus_end) w_state_nxt = S_RD_MFG3;
            S_RD_MFG3: if (w_bus_end) w_state_nxt = S_DECIDE;
            S_DECIDE: begin
                if (r_probe || (r_mfg == 16'h0000)) w_state_nxt = S_DONE;
                else if (!w_mem || !w_fit)          w_state_nxt = S_WR_SHUT;
                else                                w_state_nxt = S_WR_LO;
            end
            S_WR_LO:   if (w_bus_end) w_state_nxt = S_WR_HI;
            S_WR_HI:   if (w_bus_end) w_state_nxt = S_NEXT;
            S_WR_SHUT: if (w_bus_end) w_state_nxt = S_NEXT;
            S_NEXT:    w_state_nxt = (r_found == 4'(MAX_BOARDS)) ? S_RD_MFG0 : S_RD_TYPE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_type      <= '0;
            r_size      <= '0;
            r_mfg       <= '0;
            r_slot_idx  <= '0;
            r_slot_mask <= '0;
            r_probe     <= 1'b0;
            r_cfgout_n  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_found     <= '0;
            r_slot_map  <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_cfgout_n <= 1'b0;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_overflow <= 1'b0;
                r_found    <= '0;
                r_slot_map <= '0;
                r_probe    <= 1'b0;
            end
            if (w_sample) begin
                case (r_state)
                    S_RD_TYPE: r_type <= DBUS[3:1];
                    S_RD_SIZE: r_size <= DBUS[2:0];
                    default:   r_mfg  <= {r_mfg[11:0], ~DBUS};
                endcase
            end
            if (r_state == S_DECIDE) begin
                if (r_probe) begin
                    r_overflow <= (r_mfg != 16'h0000);
                end else if (r_mfg != 16'h0000) begin
                    r_found     <= (r_found == 4'hF) ? r_found : r_found + 4'd1;
                    r_slot_idx  <= w_idx;
                    r_slot_mask <= w_mask;
                end
            end
            if (r_state == S_WR_HI && w_bus_end) r_slot_map <= r_slot_map | r_slot_mask;
            if (r_state == S_NEXT && r_found == 4'(MAX_BOARDS)) r_probe <= 1'b1;
            if (r_state == S_DONE) begin
                r_cfgout_n <= 1'b1;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
            end
        end
    end

    // Write data is held from SETUP through the first RECOVER clock only.
    assign w_drive = w_is_wr && (r_phase != PH_REC2);
    assign w_wdata = (r_state == S_WR_HI) ? ({1'b0, r_slot_idx} + 4'd2) : 4'h0;
    assign DBUS    = w_drive ? w_wdata : 4'bz;

    assign ADDR         = w_is_bus ? {8'hE8, 7'b0, w_reg} : 23'd0;
    assign ASn          = !(w_is_bus && r_phase == PH_STROBE);
    assign UDSn         = !(w_is_bus && r_phase == PH_STROBE);
    assign LDSn         = 1'b1;
    assign RWn          = !w_is_wr;
    assign CFGOUTn      = r_cfgout_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign boards_found = r_found;
    assign slot_map     = r_slot_map;
    assign overflow     = r_overflow;
endmodule
